// File: rtl/apb_pkg.sv
// Shared APB register-file definitions.
// FSM encoding, word shift, response codes, index width helper.
package apb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int APB_WORD_SHIFT = 2;

  localparam logic APB_OKAY   = 1'b0;
  localparam logic APB_SLVERR = 1'b1;

  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_wait_ctr.sv
// Wait-state down-counter: load, decrement, zero flag.
// Only instantiated when APB_REGFILE_WAIT_EN is defined.
module apb_wait_ctr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] cnt,
  output logic       zero
);

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign zero = (cnt == 4'd0);

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer register bank with optional wait states.
// Macro APB_REGFILE_WAIT_EN enables WAIT_CYCLES wait states.
module apb_slave_regfile #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ADDR_WIDTH-1:0]        PADDR,
  input  logic                         PSEL,
  input  logic                         PENABLE,
  input  logic                         PWRITE,
  input  logic [DATA_WIDTH-1:0]        PWDATA,
  output logic [DATA_WIDTH-1:0]        PRDATA,
  output logic                         PREADY,
  output logic                         PSLVERR,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]          wr_strobe
);
  import apb_pkg::*;

  localparam int IDX_W = idx_width(NUM_REGS);

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  setup;
  logic                  access;
  logic                  dec_err;
  logic [IDX_W-1:0]      dec_idx;

  logic                  wr_q;
  logic                  err_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  commit;
  logic                  rsp_err;
  logic [DATA_WIDTH-1:0] rsp_data;

  assign setup  = PSEL & ~PENABLE;
  assign access = PSEL & PENABLE;

  assign dec_idx = PADDR[APB_WORD_SHIFT +: IDX_W];
  assign dec_err = (PADDR[APB_WORD_SHIFT-1:0] != '0)
                 | ((PADDR >> APB_WORD_SHIFT)
                    >= ADDR_WIDTH'(NUM_REGS));

  assign commit = (state == ST_RESP) & access
                & wr_q & ~err_q;

`ifdef APB_REGFILE_WAIT_EN
  localparam logic [3:0] N = 4'(WAIT_CYCLES);

  logic [3:0] cnt;
  logic       cnt_zero;
  logic       wait_done;

  apb_wait_ctr u_wait_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     ((state == ST_IDLE) & setup),
    .load_val (N),
    .dec      (state == ST_WAIT),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  assign wait_done = (cnt == 4'd1) | cnt_zero;
`endif

  // Response source: live decode from IDLE, latched otherwise.
  always_comb begin
    rsp_err  = err_q;
    rsp_data = '0;
    if (state == ST_IDLE) begin
      rsp_err = dec_err;
      if (!PWRITE && !dec_err) rsp_data = regs[dec_idx];
    end else if (!wr_q && !err_q) begin
      rsp_data = regs[idx_q];
    end
  end

  // Transfer FSM, request latches and registered APB outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      PREADY  <= 1'b0;
      PSLVERR <= APB_OKAY;
      PRDATA  <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (setup) begin
            wr_q    <= PWRITE;
            err_q   <= dec_err;
            idx_q   <= dec_idx;
            wdata_q <= PWDATA;
`ifdef APB_REGFILE_WAIT_EN
            if (N == 4'd0) begin
              state   <= ST_RESP;
              PREADY  <= 1'b1;
              PSLVERR <= rsp_err ? APB_SLVERR : APB_OKAY;
              PRDATA  <= rsp_data;
            end else begin
              state <= ST_WAIT;
            end
`else
            state   <= ST_RESP;
            PREADY  <= 1'b1;
            PSLVERR <= rsp_err ? APB_SLVERR : APB_OKAY;
            PRDATA  <= rsp_data;
`endif
          end
        end
`ifdef APB_REGFILE_WAIT_EN
        ST_WAIT: begin
          if (!PSEL) begin
            state <= ST_IDLE;
          end else if (wait_done) begin
            state   <= ST_RESP;
            PREADY  <= 1'b1;
            PSLVERR <= rsp_err ? APB_SLVERR : APB_OKAY;
            PRDATA  <= rsp_data;
          end
        end
`endif
        ST_RESP: begin
          if (!PSEL || PENABLE) begin
            state   <= ST_IDLE;
            PREADY  <= 1'b0;
            PSLVERR <= APB_OKAY;
            PRDATA  <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Register array writes and one-cycle write strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      wr_strobe <= '0;
    end else begin
      wr_strobe <= '0;
      if (commit) begin
        regs[idx_q]      <= wdata_q;
        wr_strobe[idx_q] <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Scoreboard bench for apb_slave_regfile.
// Works with and without APB_REGFILE_WAIT_EN.
module tb_apb_slave_regfile;

`ifdef APB_REGFILE_WAIT_EN
  localparam int N = 2;
`else
  localparam int N = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [15:0]  PADDR = '0;
  logic         PSEL = 1'b0;
  logic         PENABLE = 1'b0;
  logic         PWRITE = 1'b0;
  logic [31:0]  PWDATA = '0;
  logic [31:0]  PRDATA;
  logic         PREADY;
  logic         PSLVERR;
  logic [511:0] reg_q;
  logic [15:0]  wr_strobe;

  apb_slave_regfile #(
    .ADDR_WIDTH  (16),
    .DATA_WIDTH  (32),
    .NUM_REGS    (16),
    .WAIT_CYCLES (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .PADDR     (PADDR),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR),
    .reg_q     (reg_q),
    .wr_strobe (wr_strobe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } rsp_t;

  typedef struct {
    logic [15:0] mask;
    int          idx;
    logic [31:0] val;
  } stb_t;

  rsp_t        exp_q[$];
  stb_t        stb_q[$];
  logic [31:0] model [16];

  int n_vec = 0;
  int n_err = 0;
  int acc   = 0;
  bit post  = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops expected responses and strobes as the DUT shows them.
  always @(negedge clk) begin
    rsp_t r;
    stb_t s;
    if (!rst_n) begin
      acc  = 0;
      post = 0;
    end else begin
      if (post) begin
        chk("pready one cycle", 64'(PREADY), 64'd0);
        chk("prdata cleared", 64'(PRDATA), 64'd0);
        post = 0;
      end
      if (PSEL && PENABLE) acc++;
      else acc = 0;
      if (PSEL && PENABLE && PREADY) begin
        if (exp_q.size() == 0) begin
          chk("unexpected pready", 64'd1, 64'd0);
        end else begin
          r = exp_q.pop_front();
          chk("prdata", 64'(PRDATA), 64'(r.d));
          chk("pslverr", 64'(PSLVERR), 64'(r.e));
          chk("latency", 64'(acc), 64'(N + 1));
        end
        post = 1;
      end
      if (wr_strobe != '0) begin
        if (stb_q.size() == 0) begin
          chk("unexpected strobe", 64'(wr_strobe), 64'd0);
        end else begin
          s = stb_q.pop_front();
          chk("wr_strobe", 64'(wr_strobe), 64'(s.mask));
          chk("reg_q after write",
              64'(reg_q[s.idx*32 +: 32]), 64'(s.val));
        end
      end
    end
  end

  task automatic xfer(input logic [15:0] a, input logic w,
                      input logic [31:0] wd,
                      input logic [31:0] ed, input logic ee);
    stb_t s;
    bit   done;
    exp_q.push_back('{d: ed, e: ee});
    if (w && !ee) begin
      s.idx  = int'(a[5:2]);
      s.mask = 16'(1) << s.idx;
      s.val  = wd;
      stb_q.push_back(s);
      model[s.idx] = wd;
    end
    @(posedge clk); #1;
    PADDR = a; PWRITE = w; PWDATA = wd;
    PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (PREADY) done = 1;
    end
    if (!done) chk("pready timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) model[i] = '0;

    // Reset values.
    #2;
    chk("rst prdata", 64'(PRDATA), 64'd0);
    chk("rst pready", 64'(PREADY), 64'd0);
    chk("rst pslverr", 64'(PSLVERR), 64'd0);
    chk("rst reg_q zero", 64'(reg_q == '0), 64'd1);
    chk("rst wr_strobe", 64'(wr_strobe), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a write.
    @(posedge clk); #1;
    PADDR = 16'h0008; PWRITE = 1'b1; PWDATA = 32'h11111111;
    PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst pready", 64'(PREADY), 64'd0);
    chk("midrst pslverr", 64'(PSLVERR), 64'd0);
    chk("midrst prdata", 64'(PRDATA), 64'd0);
    chk("midrst reg_q zero", 64'(reg_q == '0), 64'd1);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Write then read back register 2.
    xfer(16'h0008, 1'b1, 32'hDEADBEEF, 32'h0, 1'b0);
    xfer(16'h0008, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);

    // Out-of-range write and unaligned read.
    xfer(16'h0040, 1'b1, 32'hCAFEF00D, 32'h0, 1'b1);
    xfer(16'h0006, 1'b0, 32'h0, 32'h0, 1'b1);

    // Abort a write to 0x0004 before it completes.
    @(posedge clk); #1;
    PADDR = 16'h0004; PWRITE = 1'b1; PWDATA = 32'h55AA55AA;
    PSEL = 1'b1; PENABLE = 1'b0;
`ifdef APB_REGFILE_WAIT_EN
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(negedge clk);
    chk("abort no pready", 64'(PREADY), 64'd0);
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge clk);
    chk("abort idle pready", 64'(PREADY), 64'd0);
`else
    @(posedge clk); #1;
    PSEL = 1'b0;
    @(posedge clk); #1;
    chk("abort idle pready", 64'(PREADY), 64'd0);
`endif
    xfer(16'h0004, 1'b0, 32'h0, 32'h0, 1'b0);

    // Last register and first register round trips.
    xfer(16'h003C, 1'b1, 32'h12345678, 32'h0, 1'b0);
    xfer(16'h003C, 1'b0, 32'h0, 32'h12345678, 1'b0);
    xfer(16'h0000, 1'b1, 32'hA5A5A5A5, 32'h0, 1'b0);
    xfer(16'h0000, 1'b0, 32'h0, 32'hA5A5A5A5, 1'b0);
    xfer(16'h0003, 1'b1, 32'hFFFFFFFF, 32'h0, 1'b1);

    repeat (4) @(posedge clk);
    #1;
    chk("responses pending", 64'(exp_q.size()), 64'd0);
    chk("strobes pending", 64'(stb_q.size()), 64'd0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("final reg%0d", i),
          64'(reg_q[i*32 +: 32]), 64'(model[i]));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
